i2c_cmd_arbiter: RTL and testbench

- Sequences the shared i2c master core on behalf of two requesters: CPU MMIO port (req0) and an autonomous poller/DMA port (req1).
- Performs one prescale configuration after reset, then round-robin arbitrates complete transactions.
- Drives the core's memory_control/memory_data words for each transaction, tracks core busy, and returns read data and ACK status to the winning requester.
- Sits between the bus/MMIO decode and the i2c core instance.

---
 rtl/i2c_cmd_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//
// Sequences a shared i2c master core for two requesters. After reset it issues
// the SCL prescale configuration once. It then grants complete transactions
// round-robin, drives the core's memory_control/memory_data words, tracks core
// busy, and returns read data plus an error flag (NACK or start timeout).
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   reqN_valid/ctrl/wdata    requester N transaction (ctrl: [3:0] cmd, [10:4] addr,
//                            [14:11] byte count)
//   reqN_grant               1-cycle pulse when requester N's inputs are sampled
//   reqN_done                1-cycle pulse when requester N's transaction completes
//   rsp_rdata, rsp_err       result of the last completed transaction
//   i2c_control, i2c_data    to core memory_control / memory_data
//   i2c_busy, i2c_ack_err,
//   i2c_rdata                from core; ack_err/rdata valid when busy falls
//   cfg_done                 high once prescale configuration has been issued
module i2c_cmd_arbiter #(
  parameter logic [15:0] PRESCALE      = 16'd125,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned CLR_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_ctrl,
  input  logic [31:0] req0_wdata,
  output logic        req0_grant,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [31:0] req1_ctrl,
  input  logic [31:0] req1_wdata,
  output logic        req1_grant,
  output logic        req1_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] i2c_control,
  output logic [31:0] i2c_data,
  input  logic        i2c_busy,
  input  logic        i2c_ack_err,
  input  logic [31:0] i2c_rdata,
  output logic        cfg_done
);

  localparam logic [3:0]  CmdWrite    = 4'h5;
  localparam logic [3:0]  CmdRead     = 4'h3;
  localparam logic [31:0] CfgWord     = {PRESCALE, 16'h0009};
  localparam logic [15:0] TimeoutLast = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] ClrLast     = 16'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    StCfg,
    StCfgClr,
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp,
    StClr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rr_last_q, rr_last_d;
  logic        owner_q, owner_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cfg_done_q, cfg_done_d;

  logic [31:0] ctrl_drv, data_drv;
  logic        grant0, grant1, done0, done1;
  logic        pick1, any_req;
  logic [31:0] sel_ctrl, sel_wdata;

  function automatic logic cmd_ok(input logic [3:0] cmd, input logic [3:0] count);
    return ((cmd == CmdWrite) || (cmd == CmdRead)) && (count != 4'd0);
  endfunction

  // On a tie the requester that did not win last time goes next.
  assign any_req   = req0_valid | req1_valid;
  assign pick1     = req1_valid & (~req0_valid | ~rr_last_q);
  assign sel_ctrl  = pick1 ? req1_ctrl : req0_ctrl;
  assign sel_wdata = pick1 ? req1_wdata : req0_wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    ctrl_d      = ctrl_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cfg_done_d  = cfg_done_q;
    ctrl_drv    = '0;
    data_drv    = '0;
    grant0      = 1'b0;
    grant1      = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;

    unique case (state_q)
      StCfg: begin
        ctrl_drv = CfgWord;
        cnt_d    = '0;
        state_d  = StCfgClr;
      end
      StCfgClr: begin
        if (cnt_q == ClrLast) begin
          cfg_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StIdle: begin
        if (any_req) begin
          grant0    = ~pick1;
          grant1    = pick1;
          owner_d   = pick1;
          rr_last_d = pick1;
          ctrl_d    = sel_ctrl;
          wdata_d   = sel_wdata;
          if (cmd_ok(sel_ctrl[3:0], sel_ctrl[14:11])) begin
            state_d = StIssue;
          end else begin
            // Malformed request never reaches the core.
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StIssue: begin
        ctrl_drv = ctrl_q;
        data_drv = wdata_q;
        cnt_d    = '0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        ctrl_drv = ctrl_q;
        data_drv = wdata_q;
        if (i2c_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == TimeoutLast) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitDone: begin
        ctrl_drv = ctrl_q;
        data_drv = wdata_q;
        if (!i2c_busy) begin
          rsp_rdata_d = (ctrl_q[3:0] == CmdRead) ? i2c_rdata : 32'h0;
          rsp_err_d   = i2c_ack_err;
          state_d     = StResp;
        end
      end
      StResp: begin
        done0   = ~owner_q;
        done1   = owner_q;
        cnt_d   = '0;
        state_d = StClr;
      end
      StClr: begin
        // Control stays zero long enough that the core cannot retrigger.
        if (cnt_q == ClrLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StCfg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCfg;
      cnt_q       <= '0;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      ctrl_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      ctrl_q      <= ctrl_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  // The state register sits in StCfg while rst is held; masking the decoded
  // outputs keeps the configuration word off the core until reset releases.
  assign i2c_control = rst ? 32'h0 : ctrl_drv;
  assign i2c_data    = rst ? 32'h0 : data_drv;
  assign req0_grant  = ~rst & grant0;
  assign req1_grant  = ~rst & grant1;
  assign req0_done   = ~rst & done0;
  assign req1_done   = ~rst & done1;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign cfg_done    = cfg_done_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: a per-transaction reference model (round-robin
// owner, expected latency, expected response) plus a simple i2c core model.
module tb_i2c_cmd_arbiter;

  localparam logic [31:0] CfgWord = 32'h007D_0009;
  localparam int          Timeout = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_ctrl = '0, req0_wdata = '0, req1_ctrl = '0, req1_wdata = '0;
  logic        req0_grant, req0_done, req1_grant, req1_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] i2c_control, i2c_data;
  logic        i2c_busy = 1'b0, i2c_ack_err = 1'b0;
  logic [31:0] i2c_rdata = '0;
  logic        cfg_done;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(
    .PRESCALE     (16'd125),
    .START_TIMEOUT(16),
    .CLR_CYCLES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ctrl  (req0_ctrl),
    .req0_wdata (req0_wdata),
    .req0_grant (req0_grant),
    .req0_done  (req0_done),
    .req1_valid (req1_valid),
    .req1_ctrl  (req1_ctrl),
    .req1_wdata (req1_wdata),
    .req1_grant (req1_grant),
    .req1_done  (req1_done),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .i2c_control(i2c_control),
    .i2c_data   (i2c_data),
    .i2c_busy   (i2c_busy),
    .i2c_ack_err(i2c_ack_err),
    .i2c_rdata  (i2c_rdata),
    .cfg_done   (cfg_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Shadow inputs, applied just after each rising edge.
  bit          sh_rst = 1'b1;
  bit          sh_v[2];
  logic [31:0] sh_ctrl[2];
  logic [31:0] sh_wdata[2];

  // Core model state.
  int          busy_left = 0;
  int          core_len = 1;
  bit          core_nack = 1'b0;
  bit          core_nobusy = 1'b0;
  logic [31:0] core_rd = '0;
  logic [31:0] obs_ctrl = '0, prev_ctrl = '0;

  // Reference model state.
  int          last_owner = 1;
  logic [31:0] exp_rdata = '0;
  bit          exp_err = 1'b0;

  function automatic logic [31:0] mk_ctrl(input logic [3:0] cmd, input logic [6:0] addr,
                                          input logic [3:0] cnt);
    return {17'b0, cnt, addr, cmd};
  endfunction

  // One clock cycle: drive after the edge, sample mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    rst        = sh_rst;
    req0_valid = sh_v[0];
    req1_valid = sh_v[1];
    req0_ctrl  = sh_ctrl[0];
    req0_wdata = sh_wdata[0];
    req1_ctrl  = sh_ctrl[1];
    req1_wdata = sh_wdata[1];
    // Core goes busy the cycle after a transaction word first appears.
    if (sh_rst) busy_left = 0;
    else if (obs_ctrl != 0 && prev_ctrl == 0 && obs_ctrl[3:0] != 4'h9 && !core_nobusy)
      busy_left = core_len;
    if (busy_left > 0) begin
      i2c_busy    = 1'b1;
      busy_left--;
      i2c_rdata   = $urandom;
      i2c_ack_err = 1'($urandom_range(0, 1));
    end else begin
      i2c_busy    = 1'b0;
      i2c_rdata   = core_rd;
      i2c_ack_err = core_nack;
    end
    @(negedge clk);
    prev_ctrl = obs_ctrl;
    obs_ctrl  = i2c_control;
  endtask

  task automatic do_reset(input int cycles);
    sh_rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_eq("rst_done", {req1_done, req0_done}, 0);
    end
    check_eq("rst_ctrl", i2c_control, 0);
    check_eq("rst_data", i2c_data, 0);
    check_eq("rst_grant", {req1_grant, req0_grant}, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_err", rsp_err, 0);
    check_eq("rst_cfg_done", cfg_done, 0);
    last_owner = 1;
    exp_rdata  = '0;
    exp_err    = 1'b0;
    sh_rst     = 1'b0;
    tick();
    check_eq("cfg_word", i2c_control, CfgWord);
    check_eq("cfg_data", i2c_data, 0);
    check_eq("cfg_grant", {req1_grant, req0_grant}, 0);
    check_eq("cfg_done_early", cfg_done, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("cfg_clr_ctrl", i2c_control, 0);
      check_eq("cfg_clr_grant", {req1_grant, req0_grant}, 0);
      check_eq("cfg_done_early", cfg_done, 0);
    end
  endtask

  // Presents the given valids from an idle arbiter and follows one transaction
  // through grant, completion and the clear window.
  task automatic run_one(input bit v0, input bit v1, input bit keep, input int len,
                         input bit nack, input bit nobusy, input logic [31:0] rd);
    int          own, n, lat;
    bit          ok_cmd, got;
    logic [31:0] c, w;
    logic [1:0]  onehot;
    sh_v[0]     = v0;
    sh_v[1]     = v1;
    own         = (v0 && v1) ? (1 - last_owner) : (v1 ? 1 : 0);
    core_len    = len;
    core_nack   = nack;
    core_nobusy = nobusy;
    core_rd     = rd;
    c           = sh_ctrl[own];
    w           = sh_wdata[own];
    ok_cmd      = (c[3:0] == 4'h5 || c[3:0] == 4'h3) && c[14:11] != 4'd0;
    onehot      = 2'(1 << own);
    tick();
    check_eq("grant", {req1_grant, req0_grant}, onehot);
    check_eq("idle_ctrl", i2c_control, 0);
    check_eq("cfg_done", cfg_done, 1);
    check_eq("rsp_hold_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_hold_err", rsp_err, exp_err);
    last_owner = own;
    if (!keep) begin
      sh_v[own]     = 1'b0;
      sh_ctrl[own]  = $urandom;
      sh_wdata[own] = $urandom;
    end
    if (!ok_cmd) begin
      lat = 1;            exp_rdata = '0; exp_err = 1'b1;
    end else if (nobusy) begin
      lat = Timeout + 2;  exp_rdata = '0; exp_err = 1'b1;
    end else begin
      lat = len + 3;
      exp_rdata = (c[3:0] == 4'h3) ? rd : 32'h0;
      exp_err = nack;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < lat + 4) begin
      tick();
      n++;
      check_eq("no_grant", {req1_grant, req0_grant}, 0);
      if (req0_done || req1_done) got = 1'b1;
      else begin
        check_eq("ctrl", i2c_control, ok_cmd ? c : 32'h0);
        check_eq("data", i2c_data, ok_cmd ? w : 32'h0);
      end
    end
    check_eq("done_lat", n, lat);
    check_eq("done_owner", {req1_done, req0_done}, onehot);
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("resp_ctrl", i2c_control, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("clr_ctrl", i2c_control, 0);
      check_eq("clr_quiet", {req1_grant, req0_grant, req1_done, req0_done}, 0);
    end
  endtask

  bit          rv0, rv1, rnack, rnobusy;
  int          rsel, rmode;
  logic [3:0]  rcmd, rcnt;

  initial begin
    sh_v[0] = 1'b0; sh_v[1] = 1'b0;
    sh_ctrl[0] = '0; sh_ctrl[1] = '0; sh_wdata[0] = '0; sh_wdata[1] = '0;

    // Reset exit with req0 already waiting, then a single write.
    sh_v[0] = 1'b1; sh_ctrl[0] = 32'h0000_0815; sh_wdata[0] = 32'h14;
    do_reset(5);
    run_one(1'b1, 1'b0, 1'b0, 40, 1'b0, 1'b0, 32'h0);

    // Read from req1.
    sh_ctrl[1] = 32'h0000_0813; sh_wdata[1] = 32'h0;
    run_one(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 32'hA5);

    // Contention: both held valid, grants alternate.
    sh_ctrl[0] = mk_ctrl(4'h5, 7'h22, 4'd2); sh_wdata[0] = 32'hCAFE_0001;
    sh_ctrl[1] = mk_ctrl(4'h3, 7'h50, 4'd1); sh_wdata[1] = 32'h0;
    for (int i = 0; i < 4; i++) run_one(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 32'h3C);

    // Start timeout, NACK, malformed command.
    sh_ctrl[0] = 32'h0000_0815; sh_wdata[0] = 32'h55;
    run_one(1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 32'h0);
    sh_ctrl[1] = mk_ctrl(4'h5, 7'h11, 4'd3); sh_wdata[1] = 32'h77;
    run_one(1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0, 32'h0);
    sh_ctrl[0] = 32'h0000_0817; sh_wdata[0] = 32'h99;
    run_one(1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 32'h0);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      for (int k = 0; k < 2; k++) begin
        rsel = $urandom_range(0, 9);
        rcmd = (rsel < 4) ? 4'h5 : (rsel < 8) ? 4'h3 : (rsel == 8) ? 4'h7 : 4'h5;
        rcnt = (rsel == 9) ? 4'd0 : 4'($urandom_range(1, 15));
        sh_ctrl[k]  = mk_ctrl(rcmd, 7'($urandom), rcnt);
        sh_wdata[k] = $urandom;
      end
      rmode   = $urandom_range(0, 9);
      rnack   = (rmode < 2);
      rnobusy = (rmode == 9);
      run_one(rv0, rv1, 1'b0, $urandom_range(1, 12), rnack, rnobusy, $urandom);
    end

    // Reset in the middle of a transaction aborts it without a done pulse.
    sh_ctrl[1] = mk_ctrl(4'h5, 7'h33, 4'd4); sh_wdata[1] = 32'h1234_5678;
    sh_v[1] = 1'b1;
    core_len = 30; core_nobusy = 1'b0; core_nack = 1'b0;
    tick();
    check_eq("abort_grant", {req1_grant, req0_grant}, 2'b10);
    sh_v[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("abort_no_done", {req1_done, req0_done}, 0);
    end
    check_eq("abort_busy_ctrl", i2c_control, mk_ctrl(4'h5, 7'h33, 4'd4));
    do_reset(2);
    sh_ctrl[0] = 32'h0000_0813; sh_ctrl[1] = 32'h0000_0815;
    run_one(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
